// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 field widths, special constants and
// classification helpers used by the multiply and add cores.
package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Split raw bits into sign/exponent/fraction fields
   function automatic fp32_t unpack(input logic [31:0] x);
      return fp32_t'(x);
   endfunction

   // Denormals count as zero: anything with a zero exponent field
   function automatic logic is_zero(input fp32_t x);
      return (x.exp == '0);
   endfunction

   function automatic logic is_inf(input fp32_t x);
      return (x.exp == '1) && (x.man == '0);
   endfunction

   function automatic logic is_nan(input fp32_t x);
      return (x.exp == '1) && (x.man != '0);
   endfunction

   function automatic logic [31:0] signed_inf(input logic sign);
      return sign ? NEG_INF : POS_INF;
   endfunction

   function automatic logic [31:0] signed_zero(input logic sign);
      return {sign, 31'd0};
   endfunction

endpackage

// File: rtl/fp32_add_core.sv
// fp32_add_core: combinational binary32 add using guard/round/sticky alignment,
// leading-one normalisation and round-to-nearest-even.
module fp32_add_core
   import fp32_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o
);

   fp32_t              fa;
   fp32_t              fb;
   fp32_t              fx;
   fp32_t              fy;
   logic               effSub;
   logic [7:0]         expDiff;
   logic [7:0]         shiftAmt;
   logic [26:0]        xAl;
   logic [26:0]        yExt;
   logic [53:0]        shiftWide;
   logic [26:0]        yAl;
   logic [27:0]        sum;
   logic [4:0]         msbPos;
   logic [4:0]         lzCount;
   logic [25:0]        norm;
   logic signed [9:0]  expNorm;
   logic               roundUp;
   logic [23:0]        fracRounded;
   logic signed [9:0]  expFinal;

   // Order operands by magnitude so the subtraction never goes negative, align
   // the smaller one with sticky collection, add or subtract, renormalise the
   // hidden bit to position 26 and round on the three low bits.
   always_comb begin
      fa = unpack(a_i);
      fb = unpack(b_i);
      if ({fb.exp, fb.man} > {fa.exp, fa.man}) begin
         fx = fb;
         fy = fa;
      end else begin
         fx = fa;
         fy = fb;
      end
      effSub    = fx.sign ^ fy.sign;
      expDiff   = fx.exp - fy.exp;
      shiftAmt  = (expDiff > 8'd27) ? 8'd27 : expDiff;
      xAl       = {1'b1, fx.man, 3'b000};
      yExt      = {1'b1, fy.man, 3'b000};
      shiftWide = {yExt, 27'd0} >> shiftAmt;
      yAl       = shiftWide[53:27] | {26'd0, |shiftWide[26:0]};
      sum       = effSub ? ({1'b0, xAl} - {1'b0, yAl}) : ({1'b0, xAl} + {1'b0, yAl});

      msbPos = '0;
      for (int i = 0; i < 28; i++) begin
         if (sum[i]) msbPos = 5'(i);
      end

      lzCount = '0;
      if (sum[27]) begin
         norm    = {sum[26:2], sum[1] | sum[0]};
         expNorm = 10'(fx.exp) + 10'sd1;
      end else begin
         lzCount = 5'd26 - msbPos;
         norm    = 26'(sum[25:0] << lzCount);
         expNorm = 10'(fx.exp) - 10'(lzCount);
      end
      roundUp     = norm[2] & (norm[1] | norm[0] | norm[3]);
      fracRounded = {1'b0, norm[25:3]} + 24'(roundUp);
      expFinal    = expNorm + 10'(fracRounded[23]);
      result_o    = signed_zero(1'b0);

      if (is_nan(fa) || is_nan(fb)) begin
         result_o = QNAN;
      end else if (is_inf(fa) && is_inf(fb) && (fa.sign != fb.sign)) begin
         result_o = QNAN;
      end else if (is_inf(fa)) begin
         result_o = signed_inf(fa.sign);
      end else if (is_inf(fb)) begin
         result_o = signed_inf(fb.sign);
      end else if (is_zero(fa) && is_zero(fb)) begin
         result_o = signed_zero(fa.sign & fb.sign);
      end else if (is_zero(fa)) begin
         result_o = b_i;
      end else if (is_zero(fb)) begin
         result_o = a_i;
      end else if (sum == '0) begin
         result_o = signed_zero(1'b0);
      end else if (expFinal >= 10'sd255) begin
         result_o = signed_inf(fx.sign);
      end else if (expFinal <= 10'sd0) begin
         result_o = signed_zero(fx.sign);
      end else begin
         result_o = {fx.sign, expFinal[7:0], fracRounded[22:0]};
      end
   end

endmodule

// File: rtl/fp32_mul_core.sv
// fp32_mul_core: combinational binary32 multiply with round-to-nearest-even,
// denormal inputs treated as zero, underflow flushed and overflow saturated to Inf.
module fp32_mul_core
   import fp32_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o
);

   fp32_t              fa;
   fp32_t              fb;
   logic               resSign;
   logic [47:0]        prod;
   logic [22:0]        keptFrac;
   logic               guardBit;
   logic               stickyBit;
   logic               normInc;
   logic               roundUp;
   logic [23:0]        fracRounded;
   logic signed [9:0]  expSum;

   // Multiply significands, normalise by at most one place, round the 23-bit
   // fraction (hidden bit is implicit, so a carry out of the fraction bumps the
   // exponent), then resolve specials and range limits in priority order.
   always_comb begin
      fa          = unpack(a_i);
      fb          = unpack(b_i);
      resSign     = fa.sign ^ fb.sign;
      prod        = 48'({1'b1, fa.man}) * 48'({1'b1, fb.man});
      if (prod[47]) begin
         keptFrac  = prod[46:24];
         guardBit  = prod[23];
         stickyBit = |prod[22:0];
         normInc   = 1'b1;
      end else begin
         keptFrac  = prod[45:23];
         guardBit  = prod[22];
         stickyBit = |prod[21:0];
         normInc   = 1'b0;
      end
      roundUp     = guardBit & (stickyBit | keptFrac[0]);
      fracRounded = {1'b0, keptFrac} + 24'(roundUp);
      expSum      = 10'(fa.exp) + 10'(fb.exp) - 10'(BIAS)
                    + 10'(normInc) + 10'(fracRounded[23]);
      result_o    = signed_zero(resSign);

      if (is_nan(fa) || is_nan(fb)) begin
         result_o = QNAN;
      end else if (is_inf(fa) || is_inf(fb)) begin
         result_o = (is_zero(fa) || is_zero(fb)) ? QNAN : signed_inf(resSign);
      end else if (is_zero(fa) || is_zero(fb)) begin
         result_o = signed_zero(resSign);
      end else if (expSum >= 10'sd255) begin
         result_o = signed_inf(resSign);
      end else if (expSum <= 10'sd0) begin
         result_o = signed_zero(resSign);
      end else begin
         result_o = {resSign, expSum[7:0], fracRounded[22:0]};
      end
   end

endmodule

// File: rtl/fp32_mac_unit.sv
// fp32_mac_unit: two-stage binary32 multiply-accumulate. Stage 1 registers the
// product, stage 2 folds it into the accumulator in a single cycle.
module fp32_mac_unit
   import fp32_pkg::*;
#(
   parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        acc_clr,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_c,
   output logic        out_valid
);

   logic [31:0] mulResult;
   logic [31:0] addResult;
   logic [31:0] prod_q,      prod_d;
   logic        prodValid_q, prodValid_d;
   logic [31:0] acc_q,       acc_d;
   logic        outValid_q,  outValid_d;

   assign out_a     = in_a;
   assign out_b     = in_b;
   assign out_c     = acc_q;
   assign out_valid = outValid_q;

   fp32_mul_core uMul (
      .a_i      (in_a),
      .b_i      (in_b),
      .result_o (mulResult)
   );

   fp32_add_core uAdd (
      .a_i      (prod_q),
      .b_i      (acc_q),
      .result_o (addResult)
   );

   // Next-state: clear discards both the in-flight and the incoming product
   always_comb begin
      prod_d      = prod_q;
      prodValid_d = in_valid;
      acc_d       = acc_q;
      outValid_d  = prodValid_q;
      if (in_valid) prod_d = mulResult;
      if (prodValid_q) acc_d = addResult;
      if (acc_clr) begin
         prodValid_d = 1'b0;
         acc_d       = ACC_INIT;
         outValid_d  = 1'b0;
      end
   end

   // Pipeline and accumulator registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q      <= '0;
         prodValid_q <= 1'b0;
         acc_q       <= ACC_INIT;
         outValid_q  <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         prodValid_q <= prodValid_d;
         acc_q       <= acc_d;
         outValid_q  <= outValid_d;
      end
   end

endmodule

// File: tb/tb_fp32_mac_unit.sv
// tb_fp32_mac_unit: scoreboard bench for fp32_mac_unit. Each accumulate pushes
// the hand-derived accumulator value it should leave behind; a monitor pops and
// compares whenever out_valid is seen.
module tb_fp32_mac_unit;

   logic        clk = 1'b0;
   logic        clkEn = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        acc_clr;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [31:0] out_c;
   logic        out_valid;

   logic [31:0] expQ[$];
   logic [31:0] expHead;
   int          errorCount = 0;
   int          checkCount = 0;

   fp32_mac_unit #(.ACC_INIT(32'h0000_0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .acc_clr   (acc_clr),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_valid (out_valid)
   );

   // Clock only runs once enabled so reset can be checked with no edges
   always begin
      #5;
      if (clkEn) clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // Drive one accumulate for a single cycle and queue the resulting accumulator
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expAcc);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      expQ.push_back(expAcc);
      #1;
      checkOutput("echo_a", out_a, a);
      checkOutput("echo_b", out_b, b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for outstanding results, then confirm out_valid dropped
   task automatic waitDrain();
      for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
      checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
      expQ.delete();
      @(negedge clk);
      checkOutput("valid_low_after", {31'd0, out_valid}, 32'd0);
   endtask

   // Scoreboard monitor: sample on the falling edge, away from updates
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            expHead = expQ.pop_front();
            checkOutput("acc", out_c, expHead);
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: bench did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Main sequence
   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      in_a     = '0;
      in_b     = '0;
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_out_c", out_c, 32'h0000_0000);
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      #2;
      clkEn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 2.0 * 3.0 = 6.0, then 6.0 + 1.5 * -4.0 = +0.0
      applyStimulus(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      waitDrain();
      applyStimulus(32'h3FC0_0000, 32'hC080_0000, 32'h0000_0000);
      waitDrain();

      // Back-to-back 1.0 * 1.0 accumulates every cycle
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000);
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000);
      waitDrain();

      // Overflow to +Inf, then Inf * 0 gives NaN which sticks in the accumulator
      applyStimulus(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
      applyStimulus(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
      waitDrain();

      // Clear while one product is in flight and another is presented
      in_a     = 32'h4000_0000;
      in_b     = 32'h4040_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_clr  = 1'b1;
      in_a     = 32'h3F80_0000;
      in_b     = 32'h3F80_0000;
      @(posedge clk);
      #1;
      acc_clr  = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("clr_out_c", out_c, 32'h0000_0000);
      checkOutput("clr_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("clr_hold_out_c", out_c, 32'h0000_0000);

      // Rounding: multiply drops a tiny sticky term, add exercises ties-to-even
      applyStimulus(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
      applyStimulus(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0001);
      applyStimulus(32'h3400_0000, 32'h3F80_0000, 32'h4000_0002);
      applyStimulus(32'h3400_0000, 32'h3F80_0000, 32'h4000_0002);
      // Denormal operand reads as zero; product below min normal flushes to zero
      applyStimulus(32'h0000_0001, 32'h3F80_0000, 32'h4000_0002);
      applyStimulus(32'h0080_0000, 32'h3F00_0000, 32'h4000_0002);
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
